// File: rtl/shift_rotate_unit_pkg.sv
// Shared types and FLAGS helpers for the shift/rotate unit (optional FAST_SHIFT_EN barrel path).
package shift_rotate_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SHL  = 3'd0,
        OP_SHR  = 3'd1,
        OP_SAR  = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_RCL  = 3'd5,
        OP_RCR  = 3'd6,
        OP_RSVD = 3'd7
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int CF_IDX = 0;
    localparam int PF_IDX = 2;
    localparam int AF_IDX = 4;
    localparam int ZF_IDX = 6;
    localparam int SF_IDX = 7;
    localparam int OF_IDX = 11;

    // Final FLAGS for a non-zero count, given the result's MSB/MSB-1/zero/parity features.
    function automatic logic [15:0] calc_flags(
        input shift_op_t  f_op,
        input logic [15:0] fin,
        input logic        cf,
        input logic        res_msb,
        input logic        res_msb_m1,
        input logic        res_zero,
        input logic        res_parity_even,
        input logic        orig_msb
    );
        logic [15:0] f;
        logic        arith;
        f     = fin;
        arith = 1'b0;
        f[CF_IDX] = cf;
        case (f_op)
            OP_SHL: begin
                f[OF_IDX] = res_msb ^ cf;
                arith     = 1'b1;
            end
            OP_SHR: begin
                f[OF_IDX] = orig_msb;
                arith     = 1'b1;
            end
            OP_SAR: begin
                f[OF_IDX] = 1'b0;
                arith     = 1'b1;
            end
            OP_ROL, OP_RCL: f[OF_IDX] = res_msb ^ cf;
            OP_ROR, OP_RCR: f[OF_IDX] = res_msb ^ res_msb_m1;
            default: f = fin;
        endcase
        if (arith) begin
            f[SF_IDX] = res_msb;
            f[ZF_IDX] = res_zero;
            f[PF_IDX] = res_parity_even;
            f[AF_IDX] = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/shift_rotate_unit_shift_step.sv
// Combinational one-bit shift/rotate step; byte mode touches only bits [7:0].
module shift_step
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  shift_op_t        op,
    input  logic [WIDTH-1:0] value_in,
    input  logic             cf_in,
    input  logic             is_8_bit,
    output logic [WIDTH-1:0] value_out,
    output logic             cf_out
);

    always_comb begin
        value_out = value_in;
        cf_out    = cf_in;
        if (is_8_bit) begin
            case (op)
                OP_SHL: begin
                    cf_out          = value_in[7];
                    value_out[7:0]  = {value_in[6:0], 1'b0};
                end
                OP_SHR: begin
                    cf_out          = value_in[0];
                    value_out[7:0]  = {1'b0, value_in[7:1]};
                end
                OP_SAR: begin
                    cf_out          = value_in[0];
                    value_out[7:0]  = {value_in[7], value_in[7:1]};
                end
                OP_ROL: begin
                    cf_out          = value_in[7];
                    value_out[7:0]  = {value_in[6:0], value_in[7]};
                end
                OP_ROR: begin
                    cf_out          = value_in[0];
                    value_out[7:0]  = {value_in[0], value_in[7:1]};
                end
                OP_RCL: begin
                    cf_out          = value_in[7];
                    value_out[7:0]  = {value_in[6:0], cf_in};
                end
                OP_RCR: begin
                    cf_out          = value_in[0];
                    value_out[7:0]  = {cf_in, value_in[7:1]};
                end
                default: begin
                    value_out = value_in;
                    cf_out    = cf_in;
                end
            endcase
        end else begin
            case (op)
                OP_SHL: begin
                    cf_out    = value_in[WIDTH-1];
                    value_out = {value_in[WIDTH-2:0], 1'b0};
                end
                OP_SHR: begin
                    cf_out    = value_in[0];
                    value_out = {1'b0, value_in[WIDTH-1:1]};
                end
                OP_SAR: begin
                    cf_out    = value_in[0];
                    value_out = {value_in[WIDTH-1], value_in[WIDTH-1:1]};
                end
                OP_ROL: begin
                    cf_out    = value_in[WIDTH-1];
                    value_out = {value_in[WIDTH-2:0], value_in[WIDTH-1]};
                end
                OP_ROR: begin
                    cf_out    = value_in[0];
                    value_out = {value_in[0], value_in[WIDTH-1:1]};
                end
                OP_RCL: begin
                    cf_out    = value_in[WIDTH-1];
                    value_out = {value_in[WIDTH-2:0], cf_in};
                end
                OP_RCR: begin
                    cf_out    = value_in[0];
                    value_out = {cf_in, value_in[WIDTH-1:1]};
                end
                default: begin
                    value_out = value_in;
                    cf_out    = cf_in;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// x86 shift/rotate unit, one bit per cycle; define FAST_SHIFT_EN for a single-cycle barrel path.
// Handshake: start is sampled only while busy=0; complete pulses once when out/flags_out update.
module shift_rotate_unit
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit COUNT_MASK = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [7:0]       count,
    input  logic             is_8_bit,
    input  logic [15:0]      flags_in,
    output logic [WIDTH-1:0] out,
    output logic [15:0]      flags_out,
    output logic             busy,
    output logic             complete,
    output state_t           dbg_state
);

    shift_op_t        op_in;
    logic [7:0]       n_eff;
    logic             pass_through;
    logic             a_msb;

    assign op_in        = shift_op_t'(op);
    assign n_eff        = COUNT_MASK ? {3'b000, count[4:0]} : count;
    assign pass_through = (n_eff == 8'd0) || (op_in == OP_RSVD);
    assign a_msb        = is_8_bit ? a[7] : a[WIDTH-1];

    function automatic logic [15:0] result_flags(
        input shift_op_t        f_op,
        input logic [WIDTH-1:0] v,
        input logic             cf,
        input logic             is8,
        input logic             orig_msb,
        input logic [15:0]      fin
    );
        logic msb;
        logic msb_m1;
        logic zero;
        msb    = is8 ? v[7] : v[WIDTH-1];
        msb_m1 = is8 ? v[6] : v[WIDTH-2];
        zero   = is8 ? (v[7:0] == 8'd0) : (v == '0);
        return calc_flags(f_op, fin, cf, msb, msb_m1, zero, ~^v[7:0], orig_msb);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [15:0]      flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             complete_q, complete_d;

`ifdef FAST_SHIFT_EN
    // Enough chained steps that every shift count saturates and every rotate fits after reduction.
    localparam int STEPS = WIDTH + 1;

    logic [WIDTH-1:0] chain_v [0:STEPS];
    logic             chain_c [0:STEPS];
    logic [WIDTH-1:0] stage_v [0:STEPS-1];
    logic             stage_c [0:STEPS-1];
    int               steps;

    always_comb begin
        steps = int'(n_eff);
        case (op_in)
            OP_ROL, OP_ROR: steps = int'(n_eff) % (is_8_bit ? 8 : WIDTH);
            OP_RCL, OP_RCR: steps = int'(n_eff) % (is_8_bit ? 9 : WIDTH + 1);
            default: begin
                if (int'(n_eff) > STEPS) steps = STEPS;
            end
        endcase
    end

    assign chain_v[0] = a;
    assign chain_c[0] = flags_in[CF_IDX];

    for (genvar i = 0; i < STEPS; i++) begin : g_chain
        shift_step #(.WIDTH(WIDTH)) u_step (
            .op        (op_in),
            .value_in  (chain_v[i]),
            .cf_in     (chain_c[i]),
            .is_8_bit  (is_8_bit),
            .value_out (stage_v[i]),
            .cf_out    (stage_c[i])
        );
        assign chain_v[i+1] = (i < steps) ? stage_v[i] : chain_v[i];
        assign chain_c[i+1] = (i < steps) ? stage_c[i] : chain_c[i];
    end

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        flags_d    = flags_q;
        busy_d     = 1'b0;
        complete_d = 1'b0;
        if (start) begin
            state_d    = ST_DONE;
            complete_d = 1'b1;
            if (pass_through) begin
                out_d   = a;
                flags_d = flags_in;
            end else begin
                out_d   = chain_v[STEPS];
                flags_d = result_flags(op_in, chain_v[STEPS], chain_c[STEPS],
                                       is_8_bit, a_msb, flags_in);
            end
        end
    end
`else
    logic [WIDTH-1:0] work_q, work_d;
    logic             cf_q, cf_d;
    logic [7:0]       cnt_q, cnt_d;
    shift_op_t        op_q, op_d;
    logic [15:0]      fin_q, fin_d;
    logic             msb_q, msb_d;
    logic             is8_q, is8_d;
    logic [WIDTH-1:0] step_val;
    logic             step_cf;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op        (op_q),
        .value_in  (work_q),
        .cf_in     (cf_q),
        .is_8_bit  (is8_q),
        .value_out (step_val),
        .cf_out    (step_cf)
    );

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        flags_d    = flags_q;
        busy_d     = busy_q;
        complete_d = 1'b0;
        work_d     = work_q;
        cf_d       = cf_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        fin_d      = fin_q;
        msb_d      = msb_q;
        is8_d      = is8_q;
        if (state_q == ST_SHIFT) begin
            work_d = step_val;
            cf_d   = step_cf;
            cnt_d  = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                state_d    = ST_DONE;
                busy_d     = 1'b0;
                complete_d = 1'b1;
                out_d      = step_val;
                flags_d    = result_flags(op_q, step_val, step_cf, is8_q, msb_q, fin_q);
            end
        end else if (start) begin
            if (pass_through) begin
                state_d    = ST_DONE;
                complete_d = 1'b1;
                out_d      = a;
                flags_d    = flags_in;
            end else begin
                state_d = ST_SHIFT;
                busy_d  = 1'b1;
                work_d  = a;
                cf_d    = flags_in[CF_IDX];
                cnt_d   = n_eff;
                op_d    = op_in;
                fin_d   = flags_in;
                msb_d   = a_msb;
                is8_d   = is_8_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            cf_q   <= 1'b0;
            cnt_q  <= 8'd0;
            op_q   <= OP_SHL;
            fin_q  <= 16'd0;
            msb_q  <= 1'b0;
            is8_q  <= 1'b0;
        end else begin
            work_q <= work_d;
            cf_q   <= cf_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            fin_q  <= fin_d;
            msb_q  <= msb_d;
            is8_q  <= is8_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            flags_q    <= 16'd0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            flags_q    <= flags_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
        end
    end

    assign out       = out_q;
    assign flags_out = flags_q;
    assign busy      = busy_q;
    assign complete  = complete_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench for shift_rotate_unit: directed cases plus randomized scoreboard run.
module tb_shift_rotate_unit;
    import shift_rotate_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [7:0]  count;
    logic        is_8_bit;
    logic [15:0] flags_in;

    logic [15:0] out0, flags0, out1, flags1;
    logic        busy0, complete0, busy1, complete1;
    state_t      st0, st1;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    shift_rotate_unit #(.WIDTH(16), .COUNT_MASK(1'b1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .count(count),
        .is_8_bit(is_8_bit), .flags_in(flags_in), .out(out0), .flags_out(flags0),
        .busy(busy0), .complete(complete0), .dbg_state(st0)
    );

    shift_rotate_unit #(.WIDTH(16), .COUNT_MASK(1'b0)) u_dut_full (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .count(count),
        .is_8_bit(is_8_bit), .flags_in(flags_in), .out(out1), .flags_out(flags1),
        .busy(busy1), .complete(complete1), .dbg_state(st1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model with 5-bit count masking; returns {flags, out}.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [15:0] av,
                                          input logic [7:0] c, input logic i8,
                                          input logic [15:0] fin);
        int n, w, k;
        logic [63:0] d, e, mask, mask2, ring;
        logic signed [63:0] s;
        logic [15:0] r, fo;
        logic cf, msb, msb1;
        n = int'(c[4:0]);
        w = i8 ? 8 : 16;
        d = i8 ? {56'd0, av[7:0]} : {48'd0, av};
        mask  = (64'd1 << w) - 64'd1;
        mask2 = (64'd1 << (w + 1)) - 64'd1;
        e  = 64'd0;
        cf = 1'b0;
        if (n == 0 || o == 3'd7) return {fin, av};
        case (o)
            3'd0: begin e = d << n; cf = e[w]; e = e & mask; end
            3'd1: begin e = (d << 1) >> n; cf = e[0]; e = e >> 1; end
            3'd2: begin
                s = i8 ? {{56{d[7]}}, d[7:0]} : {{48{d[15]}}, d[15:0]};
                s = (s <<< 1) >>> n;
                cf = s[0];
                e = (s >>> 1) & mask;
            end
            3'd3: begin k = n % w; e = ((d << k) | (d >> (w - k))) & mask; cf = e[0]; end
            3'd4: begin k = n % w; e = ((d >> k) | (d << (w - k))) & mask; cf = e[w-1]; end
            3'd5: begin
                ring = d | (64'(fin[0]) << w);
                k = n % (w + 1);
                ring = ((ring << k) | (ring >> (w + 1 - k))) & mask2;
                cf = ring[w];
                e = ring & mask;
            end
            default: begin
                ring = d | (64'(fin[0]) << w);
                k = n % (w + 1);
                ring = ((ring >> k) | (ring << (w + 1 - k))) & mask2;
                cf = ring[w];
                e = ring & mask;
            end
        endcase
        r    = i8 ? {av[15:8], e[7:0]} : e[15:0];
        msb  = e[w-1];
        msb1 = e[w-2];
        fo   = fin;
        fo[0] = cf;
        case (o)
            3'd0, 3'd3, 3'd5: fo[11] = msb ^ cf;
            3'd1: fo[11] = d[w-1];
            3'd2: fo[11] = 1'b0;
            default: fo[11] = msb ^ msb1;
        endcase
        if (o <= 3'd2) begin
            fo[7] = msb;
            fo[6] = (e == 64'd0);
            fo[2] = ~^r[7:0];
            fo[4] = 1'b0;
        end
        return {fo, r};
    endfunction

    task automatic drive_start(input logic [2:0] o, input logic [15:0] av, input logic [7:0] c,
                               input logic i8, input logic [15:0] f);
        @(negedge clk);
        op = o; a = av; count = c; is_8_bit = i8; flags_in = f; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns latency in cycles after the start cycle, or -1 if the budget expires.
    task automatic wait_complete(input int lat0, input int limit, output int lat, output bit busy_seen);
        lat = lat0;
        busy_seen = busy0;
        while (!complete0 && lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
            busy_seen |= busy0;
        end
        if (!complete0) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_start(3'd0, 16'hFFFF, 8'd3, 1'b0, 16'hFFFF);
        @(posedge clk);
        #1;
        checks++;
        if (out0 !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out0); end
        checks++;
        if (flags0 !== 16'h0000) begin errors++; $display("FAIL reset_flags: got %h expected 0000", flags0); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++;
        if (complete0 !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b expected 0", complete0); end
        checks++;
        if (st0 !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st0, ST_IDLE); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_shl();
        int lat; bit bs; logic [31:0] exp; int el;
        exp_q.push_back({16'h0801, 16'h0002});
        lat_q.push_back(2);
        drive_start(3'd0, 16'h8001, 8'd1, 1'b0, 16'h0000);
        wait_complete(1, 10, lat, bs);
        exp = exp_q.pop_front();
        el  = lat_q.pop_front();
        checks++;
        if (lat != el) begin errors++; $display("FAIL shl_latency: got %0d expected %0d", lat, el); end
        checks++;
        if (out0 !== exp[15:0]) begin errors++; $display("FAIL shl_out: got %h expected %h", out0, exp[15:0]); end
        checks++;
        if (flags0 !== exp[31:16]) begin errors++; $display("FAIL shl_flags: got %h expected %h", flags0, exp[31:16]); end
        @(posedge clk);
        #1;
        checks++;
        if (complete0 !== 1'b0) begin errors++; $display("FAIL shl_pulse_width: got %b expected 0", complete0); end
        checks++;
        if (out0 !== 16'h0002) begin errors++; $display("FAIL shl_hold: got %h expected 0002", out0); end
    endtask

    task automatic test_rcl8();
        int lat; bit bs; logic [31:0] exp; int el;
        exp_q.push_back({16'h08C4, 16'hAA81});
        lat_q.push_back(10);
        drive_start(3'd5, 16'hAA81, 8'd9, 1'b1, 16'h00C4);
        wait_complete(1, 20, lat, bs);
        exp = exp_q.pop_front();
        el  = lat_q.pop_front();
        checks++;
        if (lat != el) begin errors++; $display("FAIL rcl8_latency: got %0d expected %0d", lat, el); end
        checks++;
        if (out0 !== exp[15:0]) begin errors++; $display("FAIL rcl8_out: got %h expected %h", out0, exp[15:0]); end
        checks++;
        if (flags0 !== exp[31:16]) begin errors++; $display("FAIL rcl8_flags: got %h expected %h", flags0, exp[31:16]); end
    endtask

    task automatic test_sar();
        int lat; bit bs; logic [31:0] exp; int el;
        exp_q.push_back({16'h0084, 16'hF800});
        lat_q.push_back(5);
        drive_start(3'd2, 16'h8000, 8'd4, 1'b0, 16'h0010);
        wait_complete(1, 20, lat, bs);
        exp = exp_q.pop_front();
        el  = lat_q.pop_front();
        checks++;
        if (lat != el) begin errors++; $display("FAIL sar_latency: got %0d expected %0d", lat, el); end
        checks++;
        if (out0 !== exp[15:0]) begin errors++; $display("FAIL sar_out: got %h expected %h", out0, exp[15:0]); end
        checks++;
        if (flags0 !== exp[31:16]) begin errors++; $display("FAIL sar_flags: got %h expected %h", flags0, exp[31:16]); end
        checks++;
        if (bs !== 1'b1) begin errors++; $display("FAIL sar_busy: got %b expected 1", bs); end
    endtask

    task automatic test_ror_zero();
        int lat; bit bs; logic [31:0] exp; int el;
        exp_q.push_back({16'h0001, 16'h1234});
        lat_q.push_back(1);
        drive_start(3'd4, 16'h1234, 8'd0, 1'b0, 16'h0001);
        wait_complete(1, 10, lat, bs);
        exp = exp_q.pop_front();
        el  = lat_q.pop_front();
        checks++;
        if (lat != el) begin errors++; $display("FAIL ror0_latency: got %0d expected %0d", lat, el); end
        checks++;
        if (out0 !== exp[15:0]) begin errors++; $display("FAIL ror0_out: got %h expected %h", out0, exp[15:0]); end
        checks++;
        if (flags0 !== exp[31:16]) begin errors++; $display("FAIL ror0_flags: got %h expected %h", flags0, exp[31:16]); end
        checks++;
        if (bs !== 1'b0) begin errors++; $display("FAIL ror0_busy: got %b expected 0", bs); end
    endtask

    task automatic test_back_to_back();
        int lat; bit bs; logic [31:0] exp; int el;
        exp_q.push_back({16'h0004, 16'h0060});
        lat_q.push_back(6);
        drive_start(3'd0, 16'h0003, 8'd5, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        drive_start(3'd4, 16'hBEEF, 8'd0, 1'b0, 16'h0800);
        wait_complete(3, 20, lat, bs);
        exp = exp_q.pop_front();
        el  = lat_q.pop_front();
        checks++;
        if (lat != el) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, el); end
        checks++;
        if (out0 !== exp[15:0]) begin errors++; $display("FAIL b2b_out: got %h expected %h", out0, exp[15:0]); end
        checks++;
        if (flags0 !== exp[31:16]) begin errors++; $display("FAIL b2b_flags: got %h expected %h", flags0, exp[31:16]); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        drive_start(3'd0, 16'h1234, 8'd20, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        drive_start(3'd4, 16'h5555, 8'd0, 1'b0, 16'h0000);
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL abort_ignored_start: busy got %b expected 1", busy0); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy0); end
        checks++;
        if (out0 !== 16'h0000) begin errors++; $display("FAIL abort_out: got %h expected 0000", out0); end
        checks++;
        if (flags0 !== 16'h0000) begin errors++; $display("FAIL abort_flags: got %h expected 0000", flags0); end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (complete0) pulses++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_no_complete: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_shr_mask();
        int lat, lat1; bit bs;
        drive_start(3'd1, 16'h0004, 8'h21, 1'b0, 16'h0000);
        wait_complete(1, 10, lat, bs);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL shr_mask_latency: got %0d expected 2", lat); end
        checks++;
        if (out0 !== 16'h0002) begin errors++; $display("FAIL shr_mask_out: got %h expected 0002", out0); end
        checks++;
        if (flags0 !== 16'h0000) begin errors++; $display("FAIL shr_mask_flags: got %h expected 0000", flags0); end
        lat1 = (lat < 0) ? 10 : lat;
        while (!complete1 && lat1 < 60) begin
            @(posedge clk);
            #1;
            lat1++;
        end
        if (!complete1) lat1 = -1;
        checks++;
        if (lat1 != 34) begin errors++; $display("FAIL shr_full_latency: got %0d expected 34", lat1); end
        checks++;
        if (out1 !== 16'h0000) begin errors++; $display("FAIL shr_full_out: got %h expected 0000", out1); end
        checks++;
        if (flags1 !== 16'h0044) begin errors++; $display("FAIL shr_full_flags: got %h expected 0044", flags1); end
    endtask

    task automatic test_random();
        int lat; bit bs; logic [31:0] exp; int el;
        logic [2:0] o; logic [15:0] av, f; logic [7:0] c; logic i8;
        for (int t = 0; t < 40; t++) begin
            o  = 3'($urandom_range(0, 7));
            av = 16'($urandom_range(0, 65535));
            f  = 16'($urandom_range(0, 65535));
            c  = 8'($urandom_range(0, 40));
            i8 = 1'($urandom_range(0, 1));
            exp_q.push_back(model(o, av, c, i8, f));
            lat_q.push_back((c[4:0] == 5'd0 || o == 3'd7) ? 1 : int'(c[4:0]) + 1);
            drive_start(o, av, c, i8, f);
            wait_complete(1, 40, lat, bs);
            exp = exp_q.pop_front();
            el  = lat_q.pop_front();
            checks++;
            if (lat != el) begin errors++; $display("FAIL rand%0d_latency op=%0d cnt=%0d: got %0d expected %0d", t, o, c, lat, el); end
            checks++;
            if (out0 !== exp[15:0]) begin errors++; $display("FAIL rand%0d_out op=%0d a=%h cnt=%0d b8=%b: got %h expected %h", t, o, av, c, i8, out0, exp[15:0]); end
            checks++;
            if (flags0 !== exp[31:16]) begin errors++; $display("FAIL rand%0d_flags op=%0d a=%h cnt=%0d b8=%b fin=%h: got %h expected %h", t, o, av, c, i8, f, flags0, exp[31:16]); end
            checks++;
            if (bs !== (el > 1)) begin errors++; $display("FAIL rand%0d_busy: got %b expected %b", t, bs, (el > 1)); end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = 3'd0;
        a = 16'd0;
        count = 8'd0;
        is_8_bit = 1'b0;
        flags_in = 16'd0;
        test_reset();
        test_shl();
        test_rcl8();
        test_sar();
        test_ror_zero();
        test_back_to_back();
        test_reset_abort();
        test_shr_mask();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
- Multi-cycle, parametrised successor to the combinational ALU, covering x86 shift/rotate: SHL/SAL, SHR, SAR, ROL, ROR, RCL, RCR.
- Shifts one bit per cycle under a start/busy/complete handshake.
- Masks the count to 5 bits when COUNT_MASK is set (80186 behaviour).
- Sits beside the ALU in the execute stage; microcode issues start and stalls on busy.

Parameters:
- WIDTH, 16, full operand width; even, >= 16; 8-bit mode operates on bits [7:0].
- COUNT_MASK, 1, 1 = effective count is count[4:0]; 0 = full 8-bit count used.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  ShiftOp_t: SHL=0, SHR=1, SAR=2, ROL=3, ROR=4, RCL=5, RCR=6; 7 = reserved.
- a  input  WIDTH  operand.
- count  input  8  shift count.
- is_8_bit  input  1  byte operation.
- flags_in  input  16  current FLAGS.
- out  output  WIDTH  result; held until next accepted start.
- flags_out  output  16  updated FLAGS; held until next accepted start.
- busy  output  1  operation in progress.
- complete  output  1  one-cycle pulse when out/flags_out become valid.

Behaviour:
- Reset values: out=0, flags_out=0, busy=0, complete=0, state=IDLE.
- Clock/reset: one clock, clk; reset is synchronous, active-high.
- States: IDLE, SHIFT, DONE.
- Count: N = COUNT_MASK ? count[4:0] : count.
- Start acceptance: on start while IDLE or DONE, latch op, a, flags_in and N.
  - N=0 -> DONE.
  - Otherwise -> SHIFT with busy=1.
- SHIFT: each cycle performs one-bit step on the working value and working CF, then decrements the counter; after the Nth step -> DONE.
- DONE: complete=1 for exactly that cycle, busy=0, then remain DONE (outputs held) until the next start.
- Latency: complete asserts N+1 cycles after the start cycle (N=0 -> 1 cycle).
- Start while busy: ignored, no queuing.
- 8-bit mode:
  - Step operates on [7:0]; "MSB" means bit 7.
  - RCL/RCR rotate a 9-bit ring {CF, data[7:0]}; the 16-bit ring is {CF, data}.
  - out[WIDTH-1:8] = a[WIDTH-1:8].
- Flags for N >= 1:
  - CF = last bit shifted or rotated out.
  - OF:
    - SHL/ROL/RCL: MSB(result) ^ CF.
    - SHR: MSB of original operand.
    - SAR: 0.
    - ROR/RCR: MSB ^ (MSB-1) of result.
  - SHL/SHR/SAR: SF = MSB, ZF = operand-width zero test, PF = even parity of out[7:0], AF = 0.
  - Rotates: SF/ZF/PF/AF copied from flags_in.
  - All other bits copied from flags_in.
- N=0: out = a, flags_out = flags_in.
- op=7: behaves as N=0.
- reset in any state: immediate return to IDLE with reset values; any pending complete is suppressed.

Optional Feature:
- Macro: FAST_SHIFT_EN.
- Defined:
  - SHIFT state removed; a barrel-shift network computes the result and flags at start acceptance.
  - DONE is entered next cycle, so complete is always 1 cycle after start and busy is never asserted.
  - Results are bit-identical to the iterative path.
  - For rotates with N >= ring size, the barrel path reduces N modulo ring size (9 or 17 for RCL/RCR).
- Undefined: iterative path as above.

Decomposition:
- Shared package additions: ShiftOp_t enum and its width.
- CF_IDX, PF_IDX, AF_IDX, ZF_IDX, SF_IDX, OF_IDX come from the existing flags constants.
- Sub-module shift_step: combinational one-bit step.
  - Inputs: op, value, cf_in, is_8_bit.
  - Outputs: value, cf_out.
  - Instantiated once in the iterative path; chained/replicated in the FAST_SHIFT_EN path.

Test Plan:
- SHL, 16-bit, a=0x8001, N=1, flags_in=0 -> 2 cycles later: out=0x0002, CF=1, OF=1, SF=0, ZF=0, PF=0.
- RCL, 8-bit, a=0xAA81, N=9, CF_in=0 -> complete after 10 cycles: out=0xAA81, CF=0, SF/ZF/PF equal to flags_in.
- SAR, 16-bit, a=0x8000, N=4 -> out=0xF800, CF=0, OF=0, SF=1, ZF=0, PF=1, AF=0; latency 5.
- ROR, a=0x1234, count=0, flags_in=0x0001 -> next cycle: complete=1, out=0x1234, flags_out=0x0001, busy never high.
- SHR, a=0x0004, count=0x21:
  - COUNT_MASK=1 -> out=0x0002, CF=0, OF=0, latency 2.
  - COUNT_MASK=0 -> out=0x0000, CF=0, latency 34.
- SHL N=20 started; second start during cycle 3 ignored; reset in cycle 5 -> busy=0, out=0, flags_out=0 next cycle, no complete pulse.
